pc_next_reg: RTL
================

# pc_next_reg

Program-counter register and next-PC selection stage of the single-cycle RISC-V core. It holds the architectural PC and drives it to the `PC_plus_4` incrementer and instruction memory. Each cycle it takes back `PCplus4` and the branch/jump target and commits the selected next PC. It also provides boot sequencing, stall, halt/resume, misaligned-target handling and a 64-bit retired-advance counter.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned control-transfer target

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- PCplus4  in  32  PC+4 from the incrementer stage
- PCTarget  in  32  branch/JAL/JALR target from the target adder
- PCSrc  in  2  00 sequential, 01 branch (conditional), 10 JAL, 11 JALR
- branch_taken  in  1  branch condition result, used only when PCSrc=01
- stall  in  1  hold PC this cycle
- halt_req  in  1  enter HALTED (EBREAK/debug)
- resume  in  1  leave HALTED
- PC  out  32  current PC
- misaligned  out  1  one-cycle pulse: a target was trapped
- advance  out  1  one-cycle pulse: PC committed a new value in RUN
- state  out  2  00 BOOT, 01 RUN, 10 HALTED
- advance_count  out  64  number of advance pulses since reset

## Operation
- Effective target: for JALR, bit 0 of PCTarget is cleared. For branch and JAL, PCTarget is used as-is.
- Redirect: PCSrc=10 or 11, or (PCSrc=01 and branch_taken=1).
- Next PC (RUN, no stall): the effective target on redirect, otherwise PCplus4.
- FSM:
  - BOOT: entered on reset. Lasts exactly one cycle, with PC held at RESET_VECTOR. Always goes to RUN, ignoring stall, halt_req and resume.
  - RUN:
    - halt_req=1 → HALTED, PC held, no advance.
    - Otherwise stall=1 → PC held, no advance.
    - Otherwise PC updates to next PC and advance=1.
  - HALTED: PC held. resume=1 → RUN on the next edge. The PC commits nothing on that edge; execution resumes from the held PC.
- Priority per cycle: rst_n low > halt_req > stall > redirect > sequential.
- Arithmetic: 32-bit unsigned with wrap. PCplus4 of 32'hFFFF_FFFC is 32'h0000_0000 and is accepted unchanged (no trap).
- advance_count: increments by 1 on every advance pulse and wraps at 2^64.

## Timing
- Reset (rst_n low at an edge) gives:
  - PC = RESET_VECTOR
  - state = BOOT
  - misaligned = 0
  - advance = 0
  - advance_count = 0
- Reset asserted mid-RUN or mid-HALTED overrides everything on that edge.
- PC latency: one cycle. Inputs sampled at edge N appear on PC after edge N.
- misaligned and advance are registered. Each is high for the single cycle following the committing edge.
- Simultaneous events:
  - halt_req + redirect in RUN: the halt wins and the redirect is dropped. Upstream re-presents it after resume.
  - resume + halt_req in HALTED: stays HALTED.
- Inputs are ignored during BOOT and HALTED, except halt_req and resume as listed above.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined:
  - A redirect whose effective target has bit 1 set loads TRAP_VECTOR instead of the target.
  - misaligned pulses and advance=1.
- `PC_MISALIGN_TRAP_EN` undefined:
  - Bits [1:0] of the effective target are forced to 00 and loaded.
  - misaligned is tied to 0.

## Structure
- Shared package `pc_pkg`:
  - pc_src_e enum (SEQ, BR, JAL, JALR)
  - pc_state_e enum (BOOT, RUN, HALTED)
  - default RESET_VECTOR/TRAP_VECTOR constants
  - XLEN=32
- One sub-module, `pc_next_sel`: purely combinational. It computes the effective target, the redirect flag and the next PC, plus the trap decision under the macro.
- The top level holds the FSM, the PC register, the pulses and the counter.

## Test plan
- Reset then 3 free-running cycles:
  - BOOT cycle at PC=0, then PC=4, 8, C.
  - advance_count=3 and advance high 3 cycles.
- Redirects:
  - PC=8, PCSrc=01, branch_taken=1, PCTarget=0x40 → PC=0x40.
  - Same with branch_taken=0 → PC=0xC.
  - JALR with PCTarget=0x81 → PC=0x80.
- stall and halt:
  - stall high 2 cycles at PC=0x10 → PC stays 0x10 and advance_count unchanged.
  - halt_req with JAL to 0x200 → HALTED, PC=0x10.
  - resume → RUN, PC stays 0x10, then advances.
- Misaligned JAL target 0x102:
  - Macro on → PC=0x100 (TRAP_VECTOR) and misaligned pulses once.
  - Macro off → PC=0x100 (forced alignment) and misaligned=0.
- Wrap: PC=0xFFFF_FFFC, sequential → PC=0x0000_0000, no trap, advance=1.
- Reset asserted in HALTED with advance_count=5 → next cycle PC=RESET_VECTOR, state=BOOT, count=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the PC register / next-PC selection stage.
package pc_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

   typedef enum logic [1:0] {
      SEQ  = 2'b00,
      BR   = 2'b01,
      JAL  = 2'b10,
      JALR = 2'b11
   } pc_src_e;

   typedef enum logic [1:0] {
      BOOT   = 2'b00,
      RUN    = 2'b01,
      HALTED = 2'b10
   } pc_state_e;

   // Unconditional jumps always redirect; a branch only when its condition held.
   function automatic logic is_redirect(input pc_src_e src, input logic taken);
      return (src == JAL) || (src == JALR) || ((src == BR) && taken);
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: effective target, redirect flag, next PC.
// With PC_MISALIGN_TRAP_EN defined it also flags targets with bit 1 set.
module pc_next_sel
   import pc_pkg::*;
(
   input  logic [XLEN-1:0] PCplus4,
   input  logic [XLEN-1:0] PCTarget,
   input  logic [1:0]      PCSrc,
   input  logic            branch_taken,
   output logic [XLEN-1:0] next_pc,
   output logic            redirect,
   output logic            trap
);

   pc_src_e         src;
   logic [XLEN-1:0] eff_target;

   // JALR drops bit 0 of its target before any alignment decision is made.
   always_comb begin
      src        = pc_src_e'(PCSrc);
      eff_target = PCTarget;
      if (src == JALR) begin
         eff_target[0] = 1'b0;
      end
      redirect = is_redirect(src, branch_taken);
`ifdef PC_MISALIGN_TRAP_EN
      trap    = redirect && eff_target[1];
      next_pc = redirect ? eff_target : PCplus4;
`else
      trap    = 1'b0;
      next_pc = redirect ? (eff_target & ~(XLEN'(3))) : PCplus4;
`endif
   end

endmodule

// File: rtl/pc_next_reg.sv
// Program-counter register with BOOT/RUN/HALTED sequencing, stall, advance counter.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_next_reg
   import pc_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] PCplus4,
   input  logic [XLEN-1:0] PCTarget,
   input  logic [1:0]      PCSrc,
   input  logic            branch_taken,
   input  logic            stall,
   input  logic            halt_req,
   input  logic            resume,
   output logic [XLEN-1:0] PC,
   output logic            misaligned,
   output logic            advance,
   output logic [1:0]      state,
   output logic [63:0]     advance_count
);

   pc_state_e       state_q;
   logic [XLEN-1:0] pc_q;
   logic            misaligned_q;
   logic            advance_q;
   logic [63:0]     count_q;

   logic [XLEN-1:0] next_pc;
   logic            redirect;
   logic            trap;

   pc_next_sel u_next_sel (
      .PCplus4      (PCplus4),
      .PCTarget     (PCTarget),
      .PCSrc        (PCSrc),
      .branch_taken (branch_taken),
      .next_pc      (next_pc),
      .redirect     (redirect),
      .trap         (trap)
   );

   // Halt outranks stall, which outranks any commit; a halted redirect is simply lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= BOOT;
         pc_q         <= RESET_VECTOR;
         misaligned_q <= 1'b0;
         advance_q    <= 1'b0;
         count_q      <= '0;
      end else begin
         misaligned_q <= 1'b0;
         advance_q    <= 1'b0;
         unique case (state_q)
            BOOT: begin
               state_q <= RUN;
            end
            RUN: begin
               if (halt_req) begin
                  state_q <= HALTED;
               end else if (!stall) begin
                  pc_q         <= trap ? TRAP_VECTOR : next_pc;
                  misaligned_q <= trap;
                  advance_q    <= 1'b1;
                  count_q      <= count_q + 64'd1;
               end
            end
            HALTED: begin
               if (resume && !halt_req) begin
                  state_q <= RUN;
               end
            end
            default: begin
               state_q <= BOOT;
            end
         endcase
      end
   end

   assign PC            = pc_q;
   assign misaligned    = misaligned_q;
   assign advance       = advance_q;
   assign state         = state_q;
   assign advance_count = count_q;

   // redirect is informational here; the sub-module already folds it into next_pc.
   logic unused_redirect;
   assign unused_redirect = redirect;

endmodule
